// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a synchronous FIFO and sends start, data (LSB first), optional parity and stop bits.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PENULT = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] DATA_LAST   = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST   = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    FETCH,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [BW-1:0]         baud;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity;
`endif

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      baud         <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx_o         <= 1'b1;
      fifo_rd_en_o <= 1'b0;
      frame_done_o <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity       <= 1'b0;
`endif
    end else begin
      fifo_rd_en_o <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (tx_en_i && !fifo_empty_i) begin
            fifo_rd_en_o <= 1'b1;
            state        <= POP;
          end
        end
        POP: state <= FETCH;
        // FIFO read data is registered, so it is valid one cycle after the pop strobe.
        FETCH: begin
          shreg <= fifo_rd_data_i;
`ifdef FIFO_UART_TX_PARITY_EN
          parity <= ^fifo_rd_data_i;
`endif
          tx_o  <= 1'b0;
          baud  <= '0;
          state <= START;
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx_o    <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx_o  <= parity;
              state <= PARITY;
`else
              tx_o  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx_o    <= 1'b1;
            state   <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          // Registered pulse: raised one cycle early so it lands on the final stop cycle.
          frame_done_o <= (bit_cnt == STOP_LAST) && (baud == BAUD_PENULT);
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx with a FIFO model and a frame-timeline reference model.
module tb_fifo_uart_tx;
  localparam int CPB  = 4;
  localparam int DW   = 8;
  localparam int STOP = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB    = 1 + DW + PAR + STOP;
  localparam int FRAME = NB * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en, tx, busy, frame_done;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP)) dut (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty),
    .fifo_rd_data_i(fifo_rd_data), .fifo_rd_en_o(fifo_rd_en), .tx_o(tx),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int pops    = 0;
  int underflows = 0;
  int dones   = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: registered read data and registered empty flag
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_q[$];
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (q.size() == 0) underflows++;
      else begin
        fifo_rd_data <= q.pop_front();
        pops++;
      end
    end
    fifo_empty <= (q.size() == 0);
  end

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Reference model: k = cycle index within a frame timeline (-1 idle, 1 pop, 2 fetch, 3.. line bits)
  int            k = -1;
  logic          fb[0:15];
  logic [DW-1:0] mw;
  always @(posedge clk or posedge rst) begin
    if (rst) k = -1;
    else if (k < 0) begin
      if (tx_en && !fifo_empty) begin
        if (exp_q.size() == 0) chk("model_word_available", 0, 1);
        else begin
          mw = exp_q.pop_front();
          fb[0] = 1'b0;
          for (int i = 0; i < DW; i++) fb[1+i] = mw[i];
          if (PAR == 1) fb[1+DW] = ^mw;
          for (int s = 0; s < STOP; s++) fb[1+DW+PAR+s] = 1'b1;
          k = 1;
        end
      end
    end else begin
      k++;
      if (k == 3 + FRAME) k = -1;
    end
  end

  always @(negedge clk) begin
    logic etx;
    etx = (k >= 3) ? fb[(k-3)/CPB] : 1'b1;
    chk("tx", int'(tx), int'(etx));
    chk("busy", int'(busy), int'(k >= 0));
    chk("rd_en", int'(fifo_rd_en), int'(k == 1));
    chk("frame_done", int'(frame_done), int'(k == 3 + FRAME - 1));
    if (frame_done) dones++;
  end

  task automatic wait_k_ge(input int target, input string nm);
    int n = 0;
    while (k < target && n < 2000) begin @(negedge clk); n++; end
    if (k < target) chk({nm, "_timeout"}, k, target);
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    while (!(k < 0 && exp_q.size() == 0) && n < 4000) begin @(negedge clk); n++; end
    if (!(k < 0 && exp_q.size() == 0)) chk({nm, "_timeout"}, 0, 1);
    repeat (4) @(negedge clk);
  endtask

  // Sends one word from idle and pins the line bits, pop count and done position to literals.
  task automatic send_logged(input logic [DW-1:0] w, input logic [15:0] bits, input string nm);
    int p0, d0, n, dpos;
    p0 = pops; d0 = dones; n = 0; dpos = -1;
    push(w);
    @(negedge clk);
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (tx !== 1'b0) chk({nm, "_start_timeout"}, 0, 1);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (c % CPB == 2) chk($sformatf("%s_bit%0d", nm, c / CPB), int'(tx), int'(bits[c/CPB]));
      if (frame_done) dpos = c;
    end
    repeat (6) @(negedge clk);
    chk({nm, "_pops"}, pops - p0, 1);
    chk({nm, "_dones"}, dones - d0, 1);
    chk({nm, "_done_pos"}, dpos, FRAME - 1);
  endtask

  initial begin
    int p0, d0;
    // 1: reset state, then empty FIFO with enable high
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    rst = 1'b0;
    tx_en = 1'b1;
    repeat (50) @(negedge clk);
    chk("empty_no_pop", pops, 0);

    // 2: single word 0xA5
`ifdef FIFO_UART_TX_PARITY_EN
    send_logged(8'hA5, 16'b101_0100_1010, "a5");
    // 6: parity values
    send_logged(8'h07, 16'b110_0000_1110, "p07");
    send_logged(8'h00, 16'b100_0000_0000, "p00");
`else
    send_logged(8'hA5, 16'b11_0100_1010, "a5");
`endif

    // 3: three back-to-back frames
    p0 = pops; d0 = dones;
    push(8'h01); push(8'hFF); push(8'h80);
    wait_quiet("b2b");
    chk("b2b_pops", pops - p0, 3);
    chk("b2b_dones", dones - d0, 3);
    chk("b2b_fifo_left", q.size(), 0);
    chk("b2b_underflow", underflows, 0);

    // 4: enable dropped mid-frame with two words queued
    push(8'h3C); push(8'hC3);
    wait_k_ge(3 + CPB * 3, "en_drop");
    tx_en = 1'b0;
    p0 = pops;
    repeat (FRAME + 60) @(negedge clk);
    chk("en_drop_pops", pops - p0, 0);
    chk("en_drop_left", q.size(), 1);
    tx_en = 1'b1;
    wait_quiet("en_resume");
    chk("en_resume_pops", pops - p0, 1);

    // 5: asynchronous reset mid-data
    p0 = pops;
    push(8'h5A); push(8'h96);
    wait_k_ge(3 + CPB * 3, "arst");
    #1 rst = 1'b1;
    #1;
    chk("arst_tx", int'(tx), 1);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_quiet("arst_after");
    chk("arst_pops", pops - p0, 2);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0 && q.size() < 6) push(DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 149) == 0) tx_en = ~tx_en;
    end
    tx_en = 1'b1;
    wait_quiet("rand_drain");
    chk("rand_fifo_left", q.size(), 0);
    chk("rand_underflow", underflows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
